flow_buffered: RTL and testbench
================================

# flow_buffered

Parametrised successor to the `flow` handshake controller. It joins NUM_INPUTS valid/ready input channels and forks to NUM_OUTPUTS output channels, using per-cycle `consume`/`produce` masks. Unlike `flow`, each output channel has its own OUTPUT_DEPTH-entry occupancy tracker, so outputs drain independently and a slow consumer stalls the pipeline only once its slots are full. The datapath storage is external; this block issues per-output write/read slot indices for it.

## Interface
- NUM_INPUTS, default 2: number of input channels (≥1).
- NUM_OUTPUTS, default 2: number of output channels (≥1).
- OUTPUT_DEPTH, default 2: slots per output channel (≥1, any integer, not restricted to powers of two).
- PTR_W, derived: max(1, $clog2(OUTPUT_DEPTH)).
- Reset is synchronous and active-high. All state is clocked by `clk` and uses no other clock.
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- consume  in  NUM_INPUTS  inputs required this cycle.
- produce  in  NUM_OUTPUTS  outputs written this cycle.
- valid_input  in  NUM_INPUTS  input channel valid.
- ready_input  out  NUM_INPUTS  input channel ready.
- valid_output  out  NUM_OUTPUTS  output channel valid.
- ready_output  in  NUM_OUTPUTS  output channel ready.
- enable  out  1  transaction fires this cycle.
- enable_output  out  NUM_OUTPUTS  write strobe into output slot storage.
- wr_idx  out  NUM_OUTPUTS*PTR_W  per-output slot written on enable_output (output i at bits [i*PTR_W +: PTR_W]).
- rd_idx  out  NUM_OUTPUTS*PTR_W  per-output slot presented with valid_output.

## Operation
- Per output i, state is cnt[i] (0..OUTPUT_DEPTH), wr_ptr[i] and rd_ptr[i].
- space[i] = (cnt[i] < OUTPUT_DEPTH). Bypass variant: see Configuration.
- enable = AND over j of (!consume[j] | valid_input[j]) AND AND over i of (!produce[i] | space[i]) AND !rst.
- With consume = 0 and produce = 0, enable = 1. This is a no-op cycle and the parent counts it as a step.
- ready_input[j] = enable & consume[j].
- enable_output[i] = enable & produce[i].
- valid_output[i] = (cnt[i] != 0).
- pop[i] = valid_output[i] & ready_output[i].
- cnt[i] next value = cnt[i] + enable_output[i] - pop[i]. A simultaneous push and pop leaves cnt unchanged.
- wr_ptr[i] advances on enable_output[i]. rd_ptr[i] advances on pop[i].
- Both pointers wrap from OUTPUT_DEPTH-1 to 0. With OUTPUT_DEPTH=1 they are held at 0.
- wr_idx and rd_idx expose wr_ptr and rd_ptr directly.
- Inputs and outputs are evaluated independently. One output being full does not affect other outputs' valid_output.
- An unconsumed input with valid high is never acknowledged (ready_input = 0).

## Timing
- Reset values: cnt, wr_ptr, rd_ptr are 0; valid_output = 0; wr_idx = rd_idx = 0.
- While rst is high: enable = 0, ready_input = 0, enable_output = 0.
- Reset applied mid-operation discards all buffered tokens at the next edge, with no drain.
- enable, ready_input and enable_output are combinational from valid_input, consume, produce and registered cnt.
- There is no combinational path from ready_output to any output, except the bypass variant.
- Latency: enable_output[i] at cycle N gives valid_output[i] = 1 at N+1, with rd_idx equal to the wr_idx used at N.
- Throughput: one transaction per cycle sustained when ready_output is held high and OUTPUT_DEPTH ≥ 2.
- With OUTPUT_DEPTH=1 and no bypass, the rate is one transaction per 2 cycles.
- Full boundary: with cnt = OUTPUT_DEPTH and produce[i] = 1, enable = 0 even if ready_output[i] = 1 that cycle. The transaction fires the following cycle.
- Empty boundary: with cnt = 0, a push in the same cycle does not produce valid_output in that cycle; there is no fall-through.
- Assertions (simulation only): cnt never exceeds OUTPUT_DEPTH and never underflows; valid_output is stable until pop.

## Configuration
- Macro: FLOW_BUFFERED_BYPASS_EN.
- Defined: space[i] = (cnt[i] < OUTPUT_DEPTH) | ready_output[i]. A full output that pops in the same cycle accepts a push.
  - This gives full throughput at OUTPUT_DEPTH=1.
  - It adds a combinational path from ready_output to enable, ready_input and enable_output.
- Undefined: space[i] = (cnt[i] < OUTPUT_DEPTH). There is no ready_output-to-enable path.

## Test plan
- Reset hold: rst = 1 with all valid_input = 1, consume = 11, produce = 11.
  - Required: enable = 0, ready_input = 00, valid_output = 00 throughout.
  - After release: wr_idx = rd_idx = 0.
- Join: consume = 11, produce = 01, ready_output = 11, in0 valid from cycle 0, in1 valid from cycle 3.
  - Required: enable first at cycle 3, ready_input = 11 at cycle 3, valid_output[0] = 1 at cycle 4.
- No-op and masking: consume = 00, produce = 00, valid_input = 11.
  - Required: enable = 1 every cycle, ready_input = 00, all counters unchanged.
- Full stall, DEPTH=2: out1.ready = 0, produce = 10, consume = 00.
  - Required: enable = 1 on 2 cycles then 0; valid_output[1] stays high; wr_idx[1] sequence is 0, 1.
  - Required: after out1.ready rises, enable returns one cycle after the first pop; rd_idx[1] sequence is 0, 1, 0.
- Independent drain: produce = 11 for 4 cycles, out0.ready always 1, out1.ready toggling.
  - Required: output 0 pops every cycle; output 1 pops only on ready cycles.
  - Required: enable stalls only when cnt[1] = 2; no token is lost or duplicated (scoreboard by index).
- Bypass, DEPTH=1 with FLOW_BUFFERED_BYPASS_EN: produce = 01, ready_output = 01.
  - Required: enable = 1 every cycle after the first, one token per cycle.
  - Without the macro: enable alternates 1, 0.

Source files
------------

// File: rtl/flow_buffered_if.sv
// Handshake bundle for flow_buffered: join-side inputs, fork-side outputs and
// the per-output slot indices that address external output storage.
interface flow_buffered_if #(
  parameter int NUM_INPUTS   = 2,
  parameter int NUM_OUTPUTS  = 2,
  parameter int OUTPUT_DEPTH = 2
);
  localparam int PTR_W = (OUTPUT_DEPTH > 1) ? $clog2(OUTPUT_DEPTH) : 1;

  logic [NUM_INPUTS-1:0]        consume;
  logic [NUM_INPUTS-1:0]        valid_input;
  logic [NUM_INPUTS-1:0]        ready_input;
  logic [NUM_OUTPUTS-1:0]       produce;
  logic [NUM_OUTPUTS-1:0]       valid_output;
  logic [NUM_OUTPUTS-1:0]       ready_output;
  logic                         enable;
  logic [NUM_OUTPUTS-1:0]       enable_output;
  logic [NUM_OUTPUTS*PTR_W-1:0] wr_idx;
  logic [NUM_OUTPUTS*PTR_W-1:0] rd_idx;

  // Valid/ready: a channel transfers on a cycle where its valid and ready are
  // both high at the rising clock edge; valid must not drop before that edge.
  modport master (
    output consume, produce, valid_input, ready_output,
    input  ready_input, valid_output, enable, enable_output, wr_idx, rd_idx
  );

  modport slave (
    input  consume, produce, valid_input, ready_output,
    output ready_input, valid_output, enable, enable_output, wr_idx, rd_idx
  );
endinterface

// File: rtl/flow_buffered.sv
// Join/fork handshake controller with an independent occupancy tracker per output.
// Optional FLOW_BUFFERED_BYPASS_EN lets a full output accept a push while it pops.
module flow_buffered #(
  parameter int NUM_INPUTS   = 2,
  parameter int NUM_OUTPUTS  = 2,
  parameter int OUTPUT_DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst,
  flow_buffered_if.slave bus
);
  localparam int PTR_W = (OUTPUT_DEPTH > 1) ? $clog2(OUTPUT_DEPTH) : 1;
  localparam int CNT_W = $clog2(OUTPUT_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(OUTPUT_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUTPUT_DEPTH - 1);

  logic [NUM_OUTPUTS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_OUTPUTS-1:0][PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [NUM_OUTPUTS-1:0][PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [NUM_OUTPUTS-1:0]            space;
  logic [NUM_OUTPUTS-1:0]            valid;
  logic [NUM_OUTPUTS-1:0]            push;
  logic [NUM_OUTPUTS-1:0]            pop;
  logic                              inputs_ok;
  logic                              outputs_ok;
  logic                              enable;

  always_comb begin
    valid = '0;
    space = '0;
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      valid[i] = (cnt_q[i] != '0);
`ifdef FLOW_BUFFERED_BYPASS_EN
      space[i] = (cnt_q[i] < DEPTH_C) | bus.ready_output[i];
`else
      space[i] = (cnt_q[i] < DEPTH_C);
`endif
    end
  end

  // A step fires only when every required input is present and every written
  // output has a free slot; masked channels never hold the step back.
  always_comb begin
    inputs_ok  = &(~bus.consume | bus.valid_input);
    outputs_ok = &(~bus.produce | space);
    enable     = inputs_ok & outputs_ok & ~rst;
    push       = {NUM_OUTPUTS{enable}} & bus.produce;
    pop        = valid & bus.ready_output;
  end

  always_comb begin
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      if (push[i] && !pop[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (!push[i] && pop[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
      if (push[i]) begin
        wr_ptr_d[i] = (wr_ptr_q[i] == PTR_LAST) ? '0 : wr_ptr_q[i] + PTR_W'(1);
      end
      if (pop[i]) begin
        rd_ptr_d[i] = (rd_ptr_q[i] == PTR_LAST) ? '0 : rd_ptr_q[i] + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign bus.enable        = enable;
  assign bus.ready_input   = {NUM_INPUTS{enable}} & bus.consume;
  assign bus.enable_output = push;
  assign bus.valid_output  = valid;
  assign bus.wr_idx        = wr_ptr_q;
  assign bus.rd_idx        = rd_ptr_q;

`ifndef SYNTHESIS
  for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_chk
    a_cnt_max: assert property (@(posedge clk) cnt_q[g] <= DEPTH_C);
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
      !(pop[g] && (cnt_q[g] == '0)));
    a_valid_hold: assert property (@(posedge clk) disable iff (rst)
      (valid[g] && !bus.ready_output[g]) |=> valid[g]);
  end
`endif
endmodule

// File: tb/tb_flow_buffered.sv
// Randomized scoreboard bench for flow_buffered (depth 2 main unit, depth 1 rate unit).
module tb_flow_buffered;
  localparam int D  = 2;
  localparam int PW = 1;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  flow_buffered_if #(.NUM_INPUTS(2), .NUM_OUTPUTS(2), .OUTPUT_DEPTH(D)) bus ();
  flow_buffered_if #(.NUM_INPUTS(2), .NUM_OUTPUTS(2), .OUTPUT_DEPTH(1)) bus1 ();

  flow_buffered #(.NUM_INPUTS(2), .NUM_OUTPUTS(2), .OUTPUT_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );
  flow_buffered #(.NUM_INPUTS(2), .NUM_OUTPUTS(2), .OUTPUT_DEPTH(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", nm, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge and hold until the next one.
  task automatic cyc(input logic r, input logic [1:0] c, input logic [1:0] p,
                     input logic [1:0] v, input logic [1:0] ro);
    rst = r;
    bus.consume = c;
    bus.produce = p;
    bus.valid_input = v;
    bus.ready_output = ro;
    @(posedge clk);
    #1;
  endtask

  // Reference model: one queue of slot numbers per output, slots handed out in
  // arrival order modulo depth; occupancy is simply the queue length.
  logic [PW-1:0] exp_q0[$];
  logic [PW-1:0] exp_q1[$];
  int            push_n[2];
  int            pop_n[2];
  int            occ[2];
  logic          in_ok, out_ok, exp_en, full;
  logic [PW-1:0] slot;
  int            n1;
  logic          exp_en1, space1;

  initial begin
    push_n = '{0, 0};
    pop_n  = '{0, 0};
    n1 = 0;
    forever begin
      @(negedge clk);
      occ[0] = exp_q0.size();
      occ[1] = exp_q1.size();
      in_ok  = 1'b1;
      out_ok = 1'b1;
      for (int j = 0; j < 2; j++)
        if (bus.consume[j] && !bus.valid_input[j]) in_ok = 1'b0;
      for (int i = 0; i < 2; i++) begin
        full = (occ[i] >= D);
`ifdef FLOW_BUFFERED_BYPASS_EN
        if (bus.ready_output[i]) full = 1'b0;
`endif
        if (bus.produce[i] && full) out_ok = 1'b0;
      end
      exp_en = in_ok && out_ok && !rst;
      chk("enable", 32'(bus.enable), 32'(exp_en));
      chk("ready_input", 32'(bus.ready_input), 32'(exp_en ? bus.consume : 2'b00));
      chk("enable_output", 32'(bus.enable_output), 32'(exp_en ? bus.produce : 2'b00));
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("valid_output[%0d]", i), 32'(bus.valid_output[i]), 32'(occ[i] != 0));
        chk($sformatf("wr_idx[%0d]", i), 32'(bus.wr_idx[i*PW +: PW]), 32'(push_n[i] % D));
        chk($sformatf("rd_idx_ptr[%0d]", i), 32'(bus.rd_idx[i*PW +: PW]), 32'(pop_n[i] % D));
      end
      if (rst) begin
        exp_q0.delete();
        exp_q1.delete();
        push_n = '{0, 0};
        pop_n  = '{0, 0};
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (occ[i] != 0 && bus.ready_output[i]) begin
            slot = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            chk($sformatf("pop_slot[%0d]", i), 32'(bus.rd_idx[i*PW +: PW]), 32'(slot));
            pop_n[i]++;
          end
          if (exp_en && bus.produce[i]) begin
            slot = PW'(push_n[i] % D);
            if (i == 0) exp_q0.push_back(slot);
            else        exp_q1.push_back(slot);
            push_n[i]++;
          end
        end
      end

      // Depth-1 unit: produce=01, ready=01 held; model is a single-token occupancy.
      space1 = (n1 < 1);
`ifdef FLOW_BUFFERED_BYPASS_EN
      space1 = space1 | bus1.ready_output[0];
`endif
      exp_en1 = space1 && !rst;
      chk("d1_enable", 32'(bus1.enable), 32'(exp_en1));
      chk("d1_enable_output", 32'(bus1.enable_output), 32'(exp_en1 ? 2'b01 : 2'b00));
      chk("d1_valid_output", 32'(bus1.valid_output), 32'(n1 != 0 ? 2'b01 : 2'b00));
      if (rst) n1 = 0;
      else     n1 = n1 + int'(exp_en1) - int'(n1 != 0);
    end
  end

  logic [1:0] rc, rp, rv, rro;
  logic       rr;
  int         ready_bias;

  initial begin
    rst = 1'b1;
    bus.consume = '0; bus.produce = '0; bus.valid_input = '0; bus.ready_output = '0;
    bus1.consume = '0; bus1.valid_input = '0;
    bus1.produce = 2'b01; bus1.ready_output = 2'b01;
    #1;
    // reset hold with everything requested
    repeat (4) cyc(1'b1, 2'b11, 2'b11, 2'b11, 2'b11);
    // join: in1 arrives three cycles after in0
    for (int k = 0; k < 6; k++) cyc(1'b0, 2'b11, 2'b01, (k >= 3) ? 2'b11 : 2'b01, 2'b11);
    repeat (3) cyc(1'b0, 2'b00, 2'b00, 2'b00, 2'b11);
    // no-op steps with inputs valid but unconsumed
    repeat (4) cyc(1'b0, 2'b00, 2'b00, 2'b11, 2'b11);
    // full stall on output 1, then release
    repeat (4) cyc(1'b0, 2'b00, 2'b10, 2'b00, 2'b01);
    repeat (4) cyc(1'b0, 2'b00, 2'b10, 2'b00, 2'b11);
    repeat (3) cyc(1'b0, 2'b00, 2'b00, 2'b00, 2'b11);
    // independent drain: output 1 ready toggles
    for (int k = 0; k < 4; k++) cyc(1'b0, 2'b00, 2'b11, 2'b00, {k[0], 1'b1});
    repeat (4) cyc(1'b0, 2'b00, 2'b00, 2'b00, 2'b11);
    // randomized traffic with varying back-pressure and rare mid-run resets
    ready_bias = 50;
    for (int k = 0; k < 3000; k++) begin
      if (k % 100 == 0) ready_bias = $urandom_range(10, 95);
      rc = 2'($urandom_range(0, 3));
      rp = 2'($urandom_range(0, 3));
      rv = 2'($urandom_range(0, 3)) | 2'($urandom_range(0, 3));
      rro[0] = ($urandom_range(0, 99) < ready_bias);
      rro[1] = ($urandom_range(0, 99) < ready_bias);
      rr = ($urandom_range(0, 299) == 0);
      cyc(rr, rc, rp, rv, rro);
    end
    repeat (5) cyc(1'b0, 2'b00, 2'b00, 2'b00, 2'b11);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
